// File: rtl/ni_tx_packetizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ni_tx_packetizer_pkg
// Description : Shared types and constants for the NI transmit packetizer:
//               flit type codes, FSM state encoding, head-flit field order.
// Revision    : 1.0 - initial release
// ============================================================================
package ni_tx_packetizer_pkg;

    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BODY = 1'b1
    } ni_tx_state_e;

    // Head-flit field positions, counted from the MSB end of the flit.
    // The head is {dst_x, dst_y, src_x, src_y, len, zero pad}.
    localparam int HEAD_FIELD_DST_X = 0;
    localparam int HEAD_FIELD_DST_Y = 1;
    localparam int HEAD_FIELD_SRC_X = 2;
    localparam int HEAD_FIELD_SRC_Y = 3;
    localparam int HEAD_FIELD_LEN   = 4;

    // Bits occupied by the route/length fields (before the zero pad).
    function automatic int head_used_bits(input int x_w, input int y_w, input int len_w);
        return 2 * x_w + 2 * y_w + len_w;
    endfunction

endpackage : ni_tx_packetizer_pkg
`default_nettype wire

// File: rtl/ni_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : ni_tx_packetizer
// Description : Local-port network-interface transmitter. Converts a packet
//               descriptor plus payload words into HEAD/BODY/TAIL flits
//               (or a single HEADTAIL flit for empty packets) on the router's
//               forward link, honouring the backward ready.
//               Optional macro NI_TX_STATS_EN adds packet/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ni_tx_packetizer
    import ni_tx_packetizer_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int X_W     = 2,
    parameter  int Y_W     = 2,
    parameter  int MAX_LEN = 16,
    parameter  int SRC_X   = 0,
    parameter  int SRC_Y   = 0,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_desc_valid,
    output logic                   o_desc_ready,
    input  logic [X_W-1:0]         i_desc_dst_x,
    input  logic [Y_W-1:0]         i_desc_dst_y,
    input  logic [LEN_W-1:0]       i_desc_len,
    input  logic                   i_pay_valid,
    output logic                   o_pay_ready,
    input  logic [DATA_W-1:0]      i_pay_data,
    output logic                   o_flit_valid,
    output logic [FLIT_TYPE_W-1:0] o_flit_type,
    output logic [DATA_W-1:0]      o_flit_data,
    input  logic                   i_flit_ready,
    output logic                   o_err_len,
    output logic                   o_busy
`ifdef NI_TX_STATS_EN
    ,
    output logic [15:0]            o_pkt_cnt,
    output logic [15:0]            o_stall_cnt
`endif
);

    localparam int HEAD_W = head_used_bits(X_W, Y_W, LEN_W);
    localparam int PAD_W  = DATA_W - HEAD_W;

    ni_tx_state_e     r_state;
    ni_tx_state_e     w_state_next;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_next;
    logic             r_active;
    logic             r_flit_valid;
    flit_type_e       r_flit_type;
    logic [DATA_W-1:0] r_flit_data;
    logic             r_err_len;

    logic             w_slot_free;
    logic             w_desc_ready;
    logic             w_pay_ready;
    logic             w_load;
    flit_type_e       w_load_type;
    logic [DATA_W-1:0] w_load_data;
    logic             w_err;
    logic [DATA_W-1:0] w_head_data;

    // The output slot can take a new flit when empty or draining this cycle.
    assign w_slot_free = !r_flit_valid || i_flit_ready;

    // Head flit: route fields packed MSB-first, zero padded in the LSBs.
    assign w_head_data = DATA_W'({i_desc_dst_x, i_desc_dst_y, X_W'(SRC_X),
                                  Y_W'(SRC_Y), i_desc_len}) << PAD_W;

    // Next-state, handshake and flit-load decisions.
    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_desc_ready     = 1'b0;
        w_pay_ready      = 1'b0;
        w_load           = 1'b0;
        w_load_type      = FLIT_BODY;
        w_load_data      = '0;
        w_err            = 1'b0;
        case (r_state)
            IDLE: begin
                // r_active keeps ready low while held in (or just out of) reset
                w_desc_ready = r_active && w_slot_free;
                if (i_desc_valid && w_desc_ready) begin
                    if (i_desc_len > LEN_W'(MAX_LEN)) begin
                        w_err = 1'b1;
                    end else if (i_desc_len == '0) begin
                        w_load      = 1'b1;
                        w_load_type = FLIT_HEADTAIL;
                        w_load_data = w_head_data;
                    end else begin
                        w_load           = 1'b1;
                        w_load_type      = FLIT_HEAD;
                        w_load_data      = w_head_data;
                        w_remaining_next = i_desc_len;
                        w_state_next     = BODY;
                    end
                end
            end
            BODY: begin
                w_pay_ready = w_slot_free;
                if (i_pay_valid && w_pay_ready) begin
                    w_load           = 1'b1;
                    w_load_data      = i_pay_data;
                    w_load_type      = (r_remaining == LEN_W'(1)) ? FLIT_TAIL : FLIT_BODY;
                    w_remaining_next = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state, packet length tracking and the post-reset enable flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_active    <= 1'b0;
            r_err_len   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            r_active    <= 1'b1;
            r_err_len   <= w_err;
        end
    end

    // Single output register: load replaces, otherwise a handshake empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_valid <= 1'b0;
            r_flit_type  <= FLIT_BODY;
            r_flit_data  <= '0;
        end else if (w_load) begin
            r_flit_valid <= 1'b1;
            r_flit_type  <= w_load_type;
            r_flit_data  <= w_load_data;
        end else if (i_flit_ready) begin
            r_flit_valid <= 1'b0;
        end
    end

`ifdef NI_TX_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_stall_cnt;

    // Count completed packets (tail handshakes) and back-pressured cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_cnt   <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (r_flit_valid && i_flit_ready && r_flit_type[1]) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (r_flit_valid && !i_flit_ready) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_stall_cnt = r_stall_cnt;
`else
    // Statistics disabled: no counters are built.
`endif

    assign o_desc_ready = w_desc_ready;
    assign o_pay_ready  = w_pay_ready;
    assign o_flit_valid = r_flit_valid;
    assign o_flit_type  = r_flit_type;
    assign o_flit_data  = r_flit_data;
    assign o_err_len    = r_err_len;
    assign o_busy       = (r_state != IDLE) || r_flit_valid;

endmodule : ni_tx_packetizer
`default_nettype wire

// File: tb/tb_ni_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ni_tx_packetizer
// Description : Directed self-checking bench for ni_tx_packetizer
//               (SRC_X=1, SRC_Y=2; stats checks when NI_TX_STATS_EN is set).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ni_tx_packetizer;

    localparam int DATA_W  = 32;
    localparam int X_W     = 2;
    localparam int Y_W     = 2;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              desc_valid = 1'b0;
    logic              desc_ready;
    logic [X_W-1:0]    dst_x = '0;
    logic [Y_W-1:0]    dst_y = '0;
    logic [LEN_W-1:0]  dlen = '0;
    logic              pay_valid = 1'b0;
    logic              pay_ready;
    logic [DATA_W-1:0] pay_data = '0;
    logic              flit_valid;
    logic [1:0]        flit_type;
    logic [DATA_W-1:0] flit_data;
    logic              flit_ready = 1'b1;
    logic              err_len;
    logic              busy;
`ifdef NI_TX_STATS_EN
    logic [15:0]       pkt_cnt;
    logic [15:0]       stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ni_tx_packetizer #(
        .DATA_W (DATA_W),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .MAX_LEN(MAX_LEN),
        .SRC_X  (1),
        .SRC_Y  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_desc_valid(desc_valid),
        .o_desc_ready(desc_ready),
        .i_desc_dst_x(dst_x),
        .i_desc_dst_y(dst_y),
        .i_desc_len  (dlen),
        .i_pay_valid (pay_valid),
        .o_pay_ready (pay_ready),
        .i_pay_data  (pay_data),
        .o_flit_valid(flit_valid),
        .o_flit_type (flit_type),
        .o_flit_data (flit_data),
        .i_flit_ready(flit_ready),
        .o_err_len   (err_len),
        .o_busy      (busy)
`ifdef NI_TX_STATS_EN
        ,
        .o_pkt_cnt   (pkt_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    task automatic test_reset();
        logic [38:0] obs;
        #3;
        obs = {flit_valid, flit_type, flit_data, desc_ready, pay_ready, err_len, busy};
        n_total++;
        if (obs !== 39'd0) $display("FAIL reset_outputs: got %h want 0", obs);
        else n_pass++;
`ifdef NI_TX_STATS_EN
        n_total++;
        if ({pkt_cnt, stall_cnt} !== 32'd0) $display("FAIL reset_counters: got %h want 0", {pkt_cnt, stall_cnt});
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({desc_ready, busy, flit_valid} !== 3'b100) $display("FAIL post_reset_ready: got %b want 100", {desc_ready, busy, flit_valid});
        else n_pass++;
    endtask

    task automatic test_packet();
        logic [DATA_W-1:0] words [3];
        logic [DATA_W-1:0] exp_head;
        words[0] = 32'hAAAA_0001;
        words[1] = 32'hBBBB_0002;
        words[2] = 32'hCCCC_0003;
        exp_head = {2'd2, 2'd1, 2'd1, 2'd2, 5'd3, 19'd0};
        flit_ready = 1'b1;
        desc_valid = 1'b1; dst_x = 2'd2; dst_y = 2'd1; dlen = 5'd3;
        #1;
        n_total++;
        if (desc_ready !== 1'b1) $display("FAIL pkt_desc_ready: got %b want 1", desc_ready);
        else n_pass++;
        @(negedge clk);
        desc_valid = 1'b0;
        n_total++;
        if ({flit_valid, flit_type, flit_data} !== {1'b1, 2'b01, exp_head})
            $display("FAIL pkt_head: got %b/%b/%h want 1/01/%h", flit_valid, flit_type, flit_data, exp_head);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            pay_valid = 1'b1; pay_data = words[i];
            @(negedge clk);
            n_total++;
            if ({flit_valid, flit_type, flit_data} !== {1'b1, (i == 2) ? 2'b10 : 2'b00, words[i]})
                $display("FAIL pkt_word%0d: got %b/%b/%h want 1/%b/%h", i, flit_valid, flit_type, flit_data,
                         (i == 2) ? 2'b10 : 2'b00, words[i]);
            else n_pass++;
        end
        pay_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({flit_valid, busy} !== 2'b00) $display("FAIL pkt_drain: got %b want 00", {flit_valid, busy});
        else n_pass++;
    endtask

    task automatic test_zero_len();
        desc_valid = 1'b1; dst_x = 2'd3; dst_y = 2'd0; dlen = 5'd0;
        @(negedge clk);
        desc_valid = 1'b0;
        #1;
        n_total++;
        if ({flit_valid, flit_type, flit_data, desc_ready, busy} !==
            {1'b1, 2'b11, {2'd3, 2'd0, 2'd1, 2'd2, 5'd0, 19'd0}, 1'b1, 1'b1})
            $display("FAIL zero_len_headtail: got %b/%b/%h rdy=%b busy=%b want 1/11/%h rdy=1 busy=1",
                     flit_valid, flit_type, flit_data, desc_ready, busy, {2'd3, 2'd0, 2'd1, 2'd2, 5'd0, 19'd0});
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (flit_valid !== 1'b0) $display("FAIL zero_len_single: got %b want 0", flit_valid);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] exp_head;
`ifdef NI_TX_STATS_EN
        logic [15:0] stall0;
`endif
        exp_head = {2'd1, 2'd3, 2'd1, 2'd2, 5'd2, 19'd0};
        desc_valid = 1'b1; dst_x = 2'd1; dst_y = 2'd3; dlen = 5'd2;
        @(negedge clk);
        desc_valid = 1'b0;
`ifdef NI_TX_STATS_EN
        stall0 = stall_cnt;
`endif
        flit_ready = 1'b0;
        pay_valid = 1'b1; pay_data = 32'h1234_5678;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if ({flit_valid, flit_type, flit_data, pay_ready} !== {1'b1, 2'b01, exp_head, 1'b0})
                $display("FAIL stall_hold%0d: got %b/%b/%h pr=%b want 1/01/%h pr=0",
                         k, flit_valid, flit_type, flit_data, pay_ready, exp_head);
            else n_pass++;
            @(negedge clk);
        end
        flit_ready = 1'b1;
        #1;
        n_total++;
        if ({flit_type, flit_data, pay_ready} !== {2'b01, exp_head, 1'b1})
            $display("FAIL stall_release: got %b/%h pr=%b want 01/%h pr=1", flit_type, flit_data, pay_ready, exp_head);
        else n_pass++;
`ifdef NI_TX_STATS_EN
        n_total++;
        if (16'(stall_cnt - stall0) !== 16'd5) $display("FAIL stall_cnt: got %0d want 5", 16'(stall_cnt - stall0));
        else n_pass++;
`endif
        @(negedge clk);
        pay_data = 32'h9ABC_DEF0;
        n_total++;
        if ({flit_valid, flit_type, flit_data} !== {1'b1, 2'b00, 32'h1234_5678})
            $display("FAIL stall_body: got %b/%b/%h want 1/00/12345678", flit_valid, flit_type, flit_data);
        else n_pass++;
        @(negedge clk);
        pay_valid = 1'b0;
        n_total++;
        if ({flit_valid, flit_type, flit_data} !== {1'b1, 2'b10, 32'h9ABC_DEF0})
            $display("FAIL stall_tail: got %b/%b/%h want 1/10/9abcdef0", flit_valid, flit_type, flit_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_err_len();
        desc_valid = 1'b1; dst_x = 2'd1; dst_y = 2'd1; dlen = 5'd17;
        #1;
        n_total++;
        if (desc_ready !== 1'b1) $display("FAIL err_desc_ready: got %b want 1", desc_ready);
        else n_pass++;
        @(negedge clk);
        desc_valid = 1'b0;
        n_total++;
        if ({err_len, flit_valid, busy} !== 3'b100) $display("FAIL err_pulse: got %b want 100", {err_len, flit_valid, busy});
        else n_pass++;
        desc_valid = 1'b1; dst_x = 2'd0; dst_y = 2'd1; dlen = 5'd0;
        @(negedge clk);
        desc_valid = 1'b0;
        n_total++;
        if ({err_len, flit_valid, flit_type, flit_data} !== {1'b0, 1'b1, 2'b11, {2'd0, 2'd1, 2'd1, 2'd2, 5'd0, 19'd0}})
            $display("FAIL err_next_desc: got err=%b %b/%b/%h want err=0 1/11/%h", err_len, flit_valid, flit_type,
                     flit_data, {2'd0, 2'd1, 2'd1, 2'd2, 5'd0, 19'd0});
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [38:0] obs;
        desc_valid = 1'b1; dst_x = 2'd3; dst_y = 2'd3; dlen = 5'd4;
        @(negedge clk);
        desc_valid = 1'b0;
        pay_valid = 1'b1; pay_data = 32'h5555_0001;
        @(negedge clk);
        pay_data = 32'h5555_0002;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {flit_valid, flit_type, flit_data, desc_ready, pay_ready, err_len, busy};
        n_total++;
        if (obs !== 39'd0) $display("FAIL midreset_outputs: got %h want 0", obs);
        else n_pass++;
        pay_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        desc_valid = 1'b1; dst_x = 2'd0; dst_y = 2'd2; dlen = 5'd1;
        @(negedge clk);
        desc_valid = 1'b0;
        n_total++;
        if ({flit_valid, flit_type, flit_data} !== {1'b1, 2'b01, {2'd0, 2'd2, 2'd1, 2'd2, 5'd1, 19'd0}})
            $display("FAIL midreset_new_head: got %b/%b/%h want 1/01/%h", flit_valid, flit_type, flit_data,
                     {2'd0, 2'd2, 2'd1, 2'd2, 5'd1, 19'd0});
        else n_pass++;
        pay_valid = 1'b1; pay_data = 32'h0000_00EE;
        @(negedge clk);
        pay_valid = 1'b0;
        n_total++;
        if ({flit_valid, flit_type, flit_data} !== {1'b1, 2'b10, 32'h0000_00EE})
            $display("FAIL midreset_tail: got %b/%b/%h want 1/10/000000ee", flit_valid, flit_type, flit_data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] seen [4];
        logic [1:0] want [4];
`ifdef NI_TX_STATS_EN
        logic [15:0] pkt0;
        pkt0 = pkt_cnt;
`endif
        want[0] = 2'b01; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
        desc_valid = 1'b1; dst_x = 2'd2; dst_y = 2'd2; dlen = 5'd1;
        @(negedge clk);
        seen[0] = flit_valid ? flit_type : 2'bxx;
        desc_valid = 1'b0; pay_valid = 1'b1; pay_data = 32'hD00D_0001;
        @(negedge clk);
        seen[1] = flit_valid ? flit_type : 2'bxx;
        pay_valid = 1'b0; desc_valid = 1'b1; dst_x = 2'd1; dst_y = 2'd1; dlen = 5'd1;
        @(negedge clk);
        seen[2] = flit_valid ? flit_type : 2'bxx;
        n_total++;
        if (flit_data !== {2'd1, 2'd1, 2'd1, 2'd2, 5'd1, 19'd0})
            $display("FAIL b2b_head2_data: got %h want %h", flit_data, {2'd1, 2'd1, 2'd1, 2'd2, 5'd1, 19'd0});
        else n_pass++;
        desc_valid = 1'b0; pay_valid = 1'b1; pay_data = 32'hD00D_0002;
        @(negedge clk);
        seen[3] = flit_valid ? flit_type : 2'bxx;
        pay_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (seen[i] !== want[i]) $display("FAIL b2b_flit%0d: got %b want %b", i, seen[i], want[i]);
            else n_pass++;
        end
        @(negedge clk);
        n_total++;
        if ({flit_valid, busy} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {flit_valid, busy});
        else n_pass++;
`ifdef NI_TX_STATS_EN
        n_total++;
        if (16'(pkt_cnt - pkt0) !== 16'd2) $display("FAIL b2b_pkt_cnt: got %0d want 2", 16'(pkt_cnt - pkt0));
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_packet();
        test_zero_len();
        test_stall();
        test_err_len();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ni_tx_packetizer
`default_nettype wire
